// File: rtl/gfx_pkg.sv
// ---------------------------------------------------------------------------
// gfx_pkg
// Shared types and constants for the shape drawers (arc engine, line and
// rectangle sequencers) that feed the VGA pixel writer.
//
// Contents:
//   octant_e     octant selector O0..O7 for the midpoint circle walk
//   arc_state_e  control states of the arc engine
//   SCREEN_W_DEF default visible columns
//   SCREEN_H_DEF default visible rows
//   COORD_W      signed working width for screen coordinates at the
//                default 8-bit x / 7-bit y resolution
//   coord_t      signed coordinate type of width COORD_W
// ---------------------------------------------------------------------------
package gfx_pkg;

    typedef enum logic [2:0] {
        O0, O1, O2, O3, O4, O5, O6, O7
    } octant_e;

    typedef enum logic [1:0] {
        S_RELOAD,
        S_ARMED,
        S_PLOT,
        S_DONE
    } arc_state_e;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    // Two extra bits over the widest axis: one for the sign and one so that
    // centre + offset cannot overflow before clipping.
    localparam int COORD_W = 10;

    typedef logic signed [COORD_W-1:0] coord_t;

endpackage

// File: rtl/midpoint_stepper.sv
// ---------------------------------------------------------------------------
// midpoint_stepper
// Holds the midpoint-circle walk state (ox, oy, crit) and performs one
// algorithm step per advance pulse.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   load     in   initialise ox=radius, oy=0, crit=1-radius
//   advance  in   apply one step update
//   radius   in   RW-bit radius, sampled on load
//   ox       out  signed current x offset
//   oy       out  signed current y offset
//   finish   out  the step that advance would apply ends the walk (ox' < oy')
// ---------------------------------------------------------------------------
module midpoint_stepper #(
    parameter int RW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    input  logic [RW-1:0]        radius,
    output logic signed [RW+1:0] ox,
    output logic signed [RW+1:0] oy,
    output logic                 finish
);

    localparam int OW = RW + 2;
    localparam int KW = RW + 3;
    localparam logic signed [OW-1:0] ONE_O = OW'(1);
    localparam logic signed [KW-1:0] ONE_K = KW'(1);

    logic signed [KW-1:0] crit;
    logic signed [KW-1:0] crit_next;
    logic signed [KW-1:0] ox_k;
    logic signed [KW-1:0] oy_k;
    logic signed [OW-1:0] ox_next;
    logic signed [OW-1:0] oy_next;
    logic                 crit_le0;

    // Next-step values. oy always moves on; ox only moves in when the
    // decision variable is positive. The offsets are widened to the crit
    // width before doubling so the decision update never wraps.
    always_comb begin
        crit_le0 = crit[KW-1] || (crit == '0);
        oy_next  = oy + ONE_O;
        ox_next  = ox;
        if (!crit_le0) begin
            ox_next = ox - ONE_O;
        end
        oy_k = KW'(oy_next);
        ox_k = KW'(ox_next);
        if (crit_le0) begin
            crit_next = crit + (oy_k <<< 1) + ONE_K;
        end else begin
            crit_next = crit + ((oy_k - ox_k) <<< 1) + ONE_K;
        end
        finish = (ox_next < oy_next);
    end

    // Walk state: load seeds a new circle, advance commits the next step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ox   <= '0;
            oy   <= '0;
            crit <= '0;
        end else if (load) begin
            ox   <= OW'(radius);
            oy   <= '0;
            crit <= ONE_K - KW'(radius);
        end else if (advance) begin
            ox   <= ox_next;
            oy   <= oy_next;
            crit <= crit_next;
        end
    end

endmodule

// File: rtl/midpoint_arc_engine.sv
// ---------------------------------------------------------------------------
// midpoint_arc_engine
// Midpoint circle/arc plotter. Latches centre, radius, octant mask and colour
// on start, walks the midpoint algorithm and emits one octant pixel per
// accepted cycle towards the VGA pixel writer, clipping to the screen.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   level request, sampled while armed
//   done         out  drawing complete, held until start is low
//   centre_x     in   XW-bit centre x
//   centre_y     in   YW-bit centre y
//   radius       in   RW-bit radius (0 is legal)
//   octant_mask  in   bit k enables octant k
//   colour       in   pixel colour, latched on start
//   plot_ready   in   pixel writer accepts the presented pixel
//   vga_x        out  registered pixel x
//   vga_y        out  registered pixel y
//   vga_colour   out  latched colour
//   vga_plot     out  pixel valid (enabled and on screen)
// ---------------------------------------------------------------------------
module midpoint_arc_engine
    import gfx_pkg::*;
#(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int RW       = 8,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    input  logic [XW-1:0] centre_x,
    input  logic [YW-1:0] centre_y,
    input  logic [RW-1:0] radius,
    input  logic [7:0]    octant_mask,
    input  logic [2:0]    colour,
    input  logic          plot_ready,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [2:0]    vga_colour,
    output logic          vga_plot
);

    localparam int CW = ((XW > YW) ? XW : YW) + 2;
    localparam int OW = RW + 2;
    localparam logic signed [CW-1:0] LIM_X = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] LIM_Y = CW'(SCREEN_H);

    arc_state_e state;
    arc_state_e state_next;

    logic [XW-1:0]        cx_r;
    logic [YW-1:0]        cy_r;
    logic [7:0]           mask_r;
    logic [2:0]           oct;
    logic                 last;
    logic                 out_busy;

    logic signed [OW-1:0] ox;
    logic signed [OW-1:0] oy;
    logic                 finish;

    logic signed [CW-1:0] cx_c;
    logic signed [CW-1:0] cy_c;
    logic signed [CW-1:0] ox_c;
    logic signed [CW-1:0] oy_c;
    logic signed [CW-1:0] px;
    logic signed [CW-1:0] py;
    logic                 pix_plot;

    logic latch_go;
    logic consumed;
    logic slot_free;
    logic issue;
    logic step_adv;

    // A new octant pixel is issued into the single output slot whenever the
    // slot is empty or its occupant leaves this cycle. Masked/clipped pixels
    // leave after one cycle; plotted ones wait for plot_ready. The step
    // update rides on the issue of O7 so the walk keeps 8 cycles per step.
    assign latch_go  = (state == S_ARMED) && start;
    assign consumed  = out_busy && (!vga_plot || plot_ready);
    assign slot_free = !out_busy || consumed;
    assign issue     = (state == S_PLOT) && !last && slot_free;
    assign step_adv  = issue && (oct == 3'd7);

    midpoint_stepper #(
        .RW(RW)
    ) u_stepper (
        .clk     (clk),
        .rst     (rst),
        .load    (latch_go),
        .advance (step_adv),
        .radius  (radius),
        .ox      (ox),
        .oy      (oy),
        .finish  (finish)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RELOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The draw only ends once the final O7 has left the
    // output slot, and re-arming always needs start to be seen low first.
    always_comb begin
        state_next = state;
        case (state)
            S_RELOAD: if (!start) state_next = S_ARMED;
            S_ARMED:  if (start) state_next = S_PLOT;
            S_PLOT:   if (last && consumed) state_next = S_DONE;
            S_DONE:   if (!start) state_next = S_ARMED;
            default:  state_next = S_RELOAD;
        endcase
    end

    // FSM outputs.
    always_comb begin
        done = (state == S_DONE);
    end

    // Draw parameters are captured once; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cx_r       <= '0;
            cy_r       <= '0;
            mask_r     <= '0;
            vga_colour <= '0;
        end else if (latch_go) begin
            cx_r       <= centre_x;
            cy_r       <= centre_y;
            mask_r     <= octant_mask;
            vga_colour <= colour;
        end
    end

    // Octant sequencing and the "final step issued" marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oct  <= '0;
            last <= 1'b0;
        end else if (latch_go) begin
            oct  <= '0;
            last <= 1'b0;
        end else if (issue) begin
            oct <= oct + 3'd1;
            if (step_adv && finish) begin
                last <= 1'b1;
            end
        end
    end

    // Octant mirror and screen clip on signed coordinates (y grows down).
    always_comb begin
        cx_c = CW'(cx_r);
        cy_c = CW'(cy_r);
        ox_c = CW'(ox);
        oy_c = CW'(oy);
        px   = cx_c + ox_c;
        py   = cy_c - oy_c;
        case (octant_e'(oct))
            O0: begin px = cx_c + ox_c; py = cy_c - oy_c; end
            O1: begin px = cx_c + oy_c; py = cy_c - ox_c; end
            O2: begin px = cx_c - oy_c; py = cy_c - ox_c; end
            O3: begin px = cx_c - ox_c; py = cy_c - oy_c; end
            O4: begin px = cx_c - ox_c; py = cy_c + oy_c; end
            O5: begin px = cx_c - oy_c; py = cy_c + ox_c; end
            O6: begin px = cx_c + oy_c; py = cy_c + ox_c; end
            O7: begin px = cx_c + ox_c; py = cy_c + oy_c; end
            default: begin px = cx_c; py = cy_c; end
        endcase
        pix_plot = mask_r[oct] && !px[CW-1] && !py[CW-1]
                   && (px < LIM_X) && (py < LIM_Y);
    end

    // Output slot. An issued pixel is registered here; a plotted one is held
    // stable until the writer takes it, and the slot empties otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_x    <= '0;
            vga_y    <= '0;
            vga_plot <= 1'b0;
            out_busy <= 1'b0;
        end else if (latch_go) begin
            vga_plot <= 1'b0;
            out_busy <= 1'b0;
        end else if (issue) begin
            vga_x    <= px[XW-1:0];
            vga_y    <= py[YW-1:0];
            vga_plot <= pix_plot;
            out_busy <= 1'b1;
        end else if (consumed) begin
            vga_plot <= 1'b0;
            out_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_midpoint_arc_engine.sv
// ---------------------------------------------------------------------------
// tb_midpoint_arc_engine
// Self-checking bench for midpoint_arc_engine. A reference midpoint walk
// pushes the expected plotted pixels into a queue before each draw; a
// negedge monitor pops one entry per accepted pixel and compares it.
// ---------------------------------------------------------------------------
module tb_midpoint_arc_engine;
    import gfx_pkg::*;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          done;
    logic [XW-1:0] centre_x = '0;
    logic [YW-1:0] centre_y = '0;
    logic [RW-1:0] radius = '0;
    logic [7:0]    octant_mask = '0;
    logic [2:0]    colour = '0;
    logic          plot_ready = 1'b1;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;

    typedef struct {
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   plot_cycles = 0;
    bit   first_seen = 1'b0;
    int   first_x = 0;
    int   first_y = 0;

    midpoint_arc_engine #(
        .XW(XW), .YW(YW), .RW(RW), .SCREEN_W(160), .SCREEN_H(120)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done        (done),
        .centre_x    (centre_x),
        .centre_y    (centre_y),
        .radius      (radius),
        .octant_mask (octant_mask),
        .colour      (colour),
        .plot_ready  (plot_ready),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Scoreboard consumer: every pixel accepted by the writer must match the
    // head of the expected queue.
    always @(negedge clk) begin
        if (!rst && vga_plot === 1'b1) begin
            plot_cycles++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_x    = int'(vga_x);
                first_y    = int'(vga_y);
            end
            if (plot_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pixel_extra: got (%0d,%0d), required no pixel", vga_x, vga_y);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'(vga_x) !== mon_e.x || int'(vga_y) !== mon_e.y) begin
                        errors++;
                        $display("[TB] FAIL pixel: got (%0d,%0d), required (%0d,%0d)",
                                 vga_x, vga_y, mon_e.x, mon_e.y);
                    end
                end
            end
        end
    end

    // Reference midpoint walk: pushes every enabled, on-screen pixel.
    task automatic push_model(input int cx, input int cy, input int r,
                              input logic [7:0] mask,
                              output int steps, output int nplot);
        int ox, oy, crit, px, py;
        pix_t p;
        ox = r; oy = 0; crit = 1 - r; steps = 0; nplot = 0;
        do begin
            steps++;
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin px = cx + ox; py = cy - oy; end
                    1: begin px = cx + oy; py = cy - ox; end
                    2: begin px = cx - oy; py = cy - ox; end
                    3: begin px = cx - ox; py = cy - oy; end
                    4: begin px = cx - ox; py = cy + oy; end
                    5: begin px = cx - oy; py = cy + ox; end
                    6: begin px = cx + oy; py = cy + ox; end
                    default: begin px = cx + ox; py = cy + oy; end
                endcase
                if (mask[k] && px >= 0 && py >= 0 && px < 160 && py < 120) begin
                    p.x = px; p.y = py;
                    exp_q.push_back(p);
                    nplot++;
                end
            end
            oy = oy + 1;
            if (crit <= 0) begin
                crit = crit + 2 * oy + 1;
            end else begin
                ox = ox - 1;
                crit = crit + 2 * (oy - ox) + 1;
            end
        end while (ox >= oy);
    endtask

    // Drops start for one edge (so the engine arms), then requests a draw.
    task automatic start_draw(input int cx, input int cy, input int r,
                              input logic [7:0] mask, input logic [2:0] col);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        centre_x    = XW'(cx);
        centre_y    = YW'(cy);
        radius      = RW'(r);
        octant_mask = mask;
        colour      = col;
        start       = 1'b1;
        first_seen  = 1'b0;
        plot_cycles = 0;
    endtask

    // Runs cycles until done, scrambling the inputs after the latch edge.
    task automatic wait_done(input bit keep_start, input bit rand_ready,
                             output int cycles, output bit timed_out);
        bit got;
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < 4000) begin
            @(posedge clk); #1;
            if (cycles == 0) begin
                if (!keep_start) start = 1'b0;
                centre_x    = XW'($urandom);
                centre_y    = YW'($urandom);
                radius      = RW'($urandom);
                octant_mask = 8'($urandom);
                colour      = 3'($urandom);
            end
            if (rand_ready) plot_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cycles++;
            if (done === 1'b1) got = 1'b1;
        end
        timed_out = !got;
        plot_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, required 0", done); end
        checks++;
        if (vga_plot !== 1'b0) begin errors++; $display("[TB] FAIL reset_plot: got %b, required 0", vga_plot); end
        checks++;
        if (vga_x !== 8'd0 || vga_y !== 7'd0) begin
            errors++; $display("[TB] FAIL reset_xy: got (%0d,%0d), required (0,0)", vga_x, vga_y);
        end
        checks++;
        if (vga_colour !== 3'd0) begin errors++; $display("[TB] FAIL reset_colour: got %0d, required 0", vga_colour); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic_r3();
        int steps, nplot, cyc;
        bit to;
        push_model(80, 60, 3, 8'hFF, steps, nplot);
        start_draw(80, 60, 3, 8'hFF, 3'd5);
        wait_done(1'b0, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 8 * steps + 2 || steps != 3) begin
            errors++; $display("[TB] FAIL r3_cycles: got %0d (timeout=%0d), required %0d", cyc, to, 26);
        end
        checks++;
        if (plot_cycles != 24) begin errors++; $display("[TB] FAIL r3_plot_cycles: got %0d, required 24", plot_cycles); end
        checks++;
        if (!first_seen || first_x != 83 || first_y != 60) begin
            errors++; $display("[TB] FAIL r3_first: got (%0d,%0d), required (83,60)", first_x, first_y);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL r3_missing: got %0d left, required 0", exp_q.size()); end
        checks++;
        if (vga_colour !== 3'd5) begin errors++; $display("[TB] FAIL r3_colour: got %0d, required 5", vga_colour); end
        checks++;
        if (vga_plot !== 1'b0) begin errors++; $display("[TB] FAIL r3_plot_at_done: got %b, required 0", vga_plot); end
        exp_q.delete();
    endtask

    task automatic test_radius_zero();
        int steps, nplot, cyc;
        bit to;
        push_model(10, 10, 0, 8'hFF, steps, nplot);
        start_draw(10, 10, 0, 8'hFF, 3'd2);
        wait_done(1'b0, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 10) begin errors++; $display("[TB] FAIL r0_cycles: got %0d (timeout=%0d), required 10", cyc, to); end
        checks++;
        if (plot_cycles != 8) begin errors++; $display("[TB] FAIL r0_plot_cycles: got %0d, required 8", plot_cycles); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL r0_missing: got %0d left, required 0", exp_q.size()); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL r0_done_pulse: got %b, required 0", done); end
        exp_q.delete();
    endtask

    task automatic test_clip();
        int steps, nplot, cyc;
        bit to;
        push_model(0, 0, 5, 8'hFF, steps, nplot);
        start_draw(0, 0, 5, 8'hFF, 3'd7);
        wait_done(1'b0, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 8 * steps + 2) begin
            errors++; $display("[TB] FAIL clip_cycles: got %0d (timeout=%0d), required %0d", cyc, to, 8 * steps + 2);
        end
        checks++;
        if (plot_cycles != nplot) begin errors++; $display("[TB] FAIL clip_plot_cycles: got %0d, required %0d", plot_cycles, nplot); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL clip_missing: got %0d left, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_mask();
        int steps, nplot, cyc;
        bit to;
        push_model(80, 60, 4, 8'h81, steps, nplot);
        start_draw(80, 60, 4, 8'h81, 3'd1);
        wait_done(1'b0, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 8 * steps + 2) begin
            errors++; $display("[TB] FAIL mask_cycles: got %0d (timeout=%0d), required %0d", cyc, to, 8 * steps + 2);
        end
        checks++;
        if (plot_cycles != 2 * steps) begin errors++; $display("[TB] FAIL mask_plot_cycles: got %0d, required %0d", plot_cycles, 2 * steps); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL mask_missing: got %0d left, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int steps, nplot, cyc, wait_n;
        bit to;
        push_model(80, 60, 4, 8'hFF, steps, nplot);
        plot_ready = 1'b0;
        start_draw(80, 60, 4, 8'hFF, 3'd3);
        @(posedge clk); #1;
        start = 1'b0;
        plot_ready = 1'b0;
        wait_n = 0;
        @(negedge clk);
        while (vga_plot !== 1'b1 && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (vga_plot !== 1'b1 || vga_x !== 8'd84 || vga_y !== 7'd60) begin
                errors++; $display("[TB] FAIL bp_hold%0d: got (%0d,%0d) plot=%b, required (84,60) plot=1", i, vga_x, vga_y, vga_plot);
            end
        end
        @(posedge clk); #1;
        plot_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd84 || vga_y !== 7'd60) begin
            errors++; $display("[TB] FAIL bp_hold3: got (%0d,%0d) plot=%b, required (84,60) plot=1", vga_x, vga_y, vga_plot);
        end
        @(negedge clk);
        checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd80 || vga_y !== 7'd56) begin
            errors++; $display("[TB] FAIL bp_next: got (%0d,%0d) plot=%b, required (80,56) plot=1", vga_x, vga_y, vga_plot);
        end
        wait_done(1'b0, 1'b0, cyc, to);
        checks++;
        if (to || plot_cycles != nplot + 3) begin
            errors++; $display("[TB] FAIL bp_plot_cycles: got %0d (timeout=%0d), required %0d", plot_cycles, to, nplot + 3);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bp_missing: got %0d left, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_draw();
        int steps, nplot, cyc, bad;
        bit to;
        push_model(80, 60, 10, 8'hFF, steps, nplot);
        start_draw(80, 60, 10, 8'hFF, 3'd6);
        repeat (6) @(negedge clk);
        checks++;
        if (vga_plot !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_active: got plot=%b, required 1", vga_plot); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (vga_plot !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_plot: got %b, required 0", vga_plot); end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0 || vga_plot !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL rstmid_idle: got %0d active cycles, required 0", bad); end
        push_model(20, 20, 1, 8'hFF, steps, nplot);
        start_draw(20, 20, 1, 8'hFF, 3'd4);
        wait_done(1'b0, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 8 * steps + 2) begin
            errors++; $display("[TB] FAIL rstmid_redraw: got %0d (timeout=%0d), required %0d", cyc, to, 8 * steps + 2);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL rstmid_missing: got %0d left, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_done_hold();
        int steps, nplot, cyc, bad;
        bit to;
        push_model(30, 40, 2, 8'hFF, steps, nplot);
        start_draw(30, 40, 2, 8'hFF, 3'd2);
        wait_done(1'b1, 1'b0, cyc, to);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b1) bad++;
        end
        checks++;
        if (to || bad != 0) begin errors++; $display("[TB] FAIL hold_done: got %0d low cycles (timeout=%0d), required 0", bad, to); end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL hold_clear: got %b, required 0", done); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL hold_missing: got %0d left, required 0", exp_q.size()); end
        exp_q.delete();
        push_model(50, 50, 3, 8'hFF, steps, nplot);
        start_draw(50, 50, 3, 8'hFF, 3'd1);
        wait_done(1'b0, 1'b0, cyc, to);
        checks++;
        if (to || cyc != 8 * steps + 2 || exp_q.size() != 0) begin
            errors++; $display("[TB] FAIL hold_redraw: got %0d cycles %0d left, required %0d cycles 0 left", cyc, exp_q.size(), 8 * steps + 2);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int steps, nplot, cyc;
        bit to;
        logic [7:0] m;
        m = 8'($urandom);
        push_model(150, 110, 7, m, steps, nplot);
        start_draw(150, 110, 7, m, 3'd3);
        wait_done(1'b0, 1'b1, cyc, to);
        checks++;
        if (to || exp_q.size() != 0 || plot_cycles < nplot) begin
            errors++; $display("[TB] FAIL b2b_first: got %0d left %0d plots (timeout=%0d), required 0 left %0d plots", exp_q.size(), plot_cycles, to, nplot);
        end
        exp_q.delete();
        push_model(40, 30, 20, 8'h3C, steps, nplot);
        start_draw(40, 30, 20, 8'h3C, 3'd6);
        wait_done(1'b0, 1'b1, cyc, to);
        checks++;
        if (to || exp_q.size() != 0 || plot_cycles < nplot) begin
            errors++; $display("[TB] FAIL b2b_second: got %0d left %0d plots (timeout=%0d), required 0 left %0d plots", exp_q.size(), plot_cycles, to, nplot);
        end
        checks++;
        if (vga_colour !== 3'd6) begin errors++; $display("[TB] FAIL b2b_colour: got %0d, required 6", vga_colour); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_r3();
        test_radius_zero();
        test_clip();
        test_mask();
        test_backpressure();
        test_reset_mid_draw();
        test_done_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
